// File: rtl/tfe_if_pkg.sv
// -----------------------------------------------------------------------------
// tfe_if_pkg
// Shared definitions for the TFE interface blocks: the default feature address
// width, the width of the saturating overflow counter, and a ceil(log2) helper
// used to size pointers, levels and channel indices.
// -----------------------------------------------------------------------------
package tfe_if_pkg;

    localparam int TFE_AW_DEF = 12;
    localparam int TFE_OVF_W  = 16;

    // ceil(log2(v)); returns 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tfe_sync_fifo.sv
// -----------------------------------------------------------------------------
// tfe_sync_fifo
// Single-clock FIFO with an explicit occupancy counter, registered full/empty
// flags and a registered read-data output that updates only on a pop.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write strobe (ignored while full)
//   i_din       : write data
//   i_pop       : read strobe (ignored while empty)
//   o_dout      : head entry captured on the last accepted pop
//   o_level     : current occupancy
//   o_full      : occupancy == DEPTH
//   o_empty     : occupancy == 0
// -----------------------------------------------------------------------------
module tfe_sync_fifo
    import tfe_if_pkg::*;
#(
    parameter int AW    = TFE_AW_DEF,
    parameter int DEPTH = 16,
    localparam int PW   = clog2(DEPTH),
    localparam int LW   = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [AW-1:0] i_din,
    input  logic          i_pop,
    output logic [AW-1:0] o_dout,
    output logic [LW-1:0] o_level,
    output logic          o_full,
    output logic          o_empty
);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_full;
    logic          r_empty;
    logic [AW-1:0] r_dout;

    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level_nxt;

    // Flags are registered, so a write into an empty FIFO cannot be popped
    // in the same cycle: there is no write-to-read bypass.
    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop  & ~r_empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    // Storage carries no reset; only pointers and flags are control state.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_dout  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
                r_dout <= r_mem[r_rptr];
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    assign o_dout  = r_dout;
    assign o_level = r_level;
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/tfe_ext_dispatch.sv
// -----------------------------------------------------------------------------
// tfe_ext_dispatch
// Queues feature addresses of flows that reached threshold and hands them to
// NCH external consumers through a round-robin arbiter gated by per-channel
// inflight credits. Writes into a full queue are counted, not silently lost.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   reach_thrh    : enqueue strobe, i_fea_addr is the address to queue
//   rd_req[NCH]   : per-channel level request for a new address
//   done[NCH]     : per-channel pulse returning one credit
//   o_fea_addr    : dispatched address, o_fea_addr_v pulses one cycle
//   o_fea_ch      : channel owning o_fea_addr
//   fifo_empty/full/level : queue status
//   overflow_cnt  : saturating count of dropped writes
//   err_done      : sticky, done seen on a channel with no inflight address
// -----------------------------------------------------------------------------
module tfe_ext_dispatch
    import tfe_if_pkg::*;
#(
    parameter int AW       = TFE_AW_DEF,
    parameter int DEPTH    = 16,
    parameter int NCH      = 4,
    parameter int MAX_INFL = 2,
    localparam int CW      = (NCH > 1) ? clog2(NCH) : 1,
    localparam int LW      = clog2(DEPTH + 1),
    localparam int IW      = clog2(MAX_INFL + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reach_thrh,
    input  logic [AW-1:0]        i_fea_addr,
    input  logic [NCH-1:0]       rd_req,
    input  logic [NCH-1:0]       done,
    output logic [AW-1:0]        o_fea_addr,
    output logic                 o_fea_addr_v,
    output logic [CW-1:0]        o_fea_ch,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic [LW-1:0]        fifo_level,
    output logic [TFE_OVF_W-1:0] overflow_cnt,
    output logic                 err_done
);

    logic [IW-1:0]        r_infl [NCH];
    logic [CW-1:0]        r_rr;
    logic                 r_v;
    logic [CW-1:0]        r_ch;
    logic [TFE_OVF_W-1:0] r_ovf;
    logic                 r_err;

    logic [NCH-1:0]       w_elig;
    logic [NCH-1:0]       w_nz;
    logic                 w_gnt;
    logic [CW-1:0]        w_gnt_ch;
    int                   w_idx;

    tfe_sync_fifo #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (reach_thrh),
        .i_din   (i_fea_addr),
        .i_pop   (w_gnt),
        .o_dout  (o_fea_addr),
        .o_level (fifo_level),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_nz[c]   = (r_infl[c] != '0);
            w_elig[c] = rd_req[c] && (r_infl[c] < IW'(MAX_INFL));
        end
    end

    // First eligible channel at or after the round-robin pointer, with wrap.
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_ch = '0;
        w_idx    = 0;
        for (int i = 0; i < NCH; i++) begin
            w_idx = (int'(r_rr) + i) % NCH;
            if (!w_gnt && w_elig[w_idx]) begin
                w_gnt    = 1'b1;
                w_gnt_ch = CW'(w_idx);
            end
        end
        if (fifo_empty) begin
            w_gnt = 1'b0;
        end
    end

    // A grant and a valid done on the same channel cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                r_infl[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if ((w_gnt && (w_gnt_ch == CW'(c))) && !(done[c] && w_nz[c])) begin
                    r_infl[c] <= r_infl[c] + IW'(1);
                end else if (!(w_gnt && (w_gnt_ch == CW'(c))) && (done[c] && w_nz[c])) begin
                    r_infl[c] <= r_infl[c] - IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr  <= '0;
            r_v   <= 1'b0;
            r_ch  <= '0;
            r_ovf <= '0;
            r_err <= 1'b0;
        end else begin
            r_v <= w_gnt;
            if (w_gnt) begin
                r_ch <= w_gnt_ch;
                r_rr <= CW'((int'(w_gnt_ch) + 1) % NCH);
            end
            // Full is the registered flag, so a same-cycle pop does not save the write.
            if (reach_thrh && fifo_full && (r_ovf != '1)) begin
                r_ovf <= r_ovf + TFE_OVF_W'(1);
            end
            if (|(done & ~w_nz)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_fea_addr_v = r_v;
    assign o_fea_ch     = r_ch;
    assign overflow_cnt = r_ovf;
    assign err_done     = r_err;

endmodule

// File: tb/tb_tfe_ext_dispatch.sv
module tb_tfe_ext_dispatch;
    localparam int AW = 12;
    localparam int DEPTH = 16;
    localparam int NCH = 4;
    localparam int MAX_INFL = 2;
    localparam int CW = 2;
    localparam int LW = 5;

    logic           clk;
    logic           rst_n;
    logic           reach_thrh;
    logic [AW-1:0]  i_fea_addr;
    logic [NCH-1:0] rd_req;
    logic [NCH-1:0] done;
    logic [AW-1:0]  o_fea_addr;
    logic           o_fea_addr_v;
    logic [CW-1:0]  o_fea_ch;
    logic           fifo_empty;
    logic           fifo_full;
    logic [LW-1:0]  fifo_level;
    logic [15:0]    overflow_cnt;
    logic           err_done;

    int n_vec = 0;
    int n_err = 0;

    // expected dispatches: {channel, address}
    logic [CW+AW-1:0] sb[$];

    tfe_ext_dispatch #(
        .AW(AW), .DEPTH(DEPTH), .NCH(NCH), .MAX_INFL(MAX_INFL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .reach_thrh(reach_thrh), .i_fea_addr(i_fea_addr),
        .rd_req(rd_req), .done(done), .o_fea_addr(o_fea_addr), .o_fea_addr_v(o_fea_addr_v),
        .o_fea_ch(o_fea_ch), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_level(fifo_level), .overflow_cnt(overflow_cnt), .err_done(err_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every dispatch pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && o_fea_addr_v) begin
            if (sb.size() == 0) begin
                check("spurious_v", 32'(o_fea_addr_v), 32'd0);
            end else begin
                logic [CW+AW-1:0] e;
                e = sb.pop_front();
                check("disp_addr", 32'(o_fea_addr), 32'(e[AW-1:0]));
                check("disp_ch", 32'(o_fea_ch), 32'(e[CW+AW-1:AW]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_disp(input logic [AW-1:0] a, input int ch);
        sb.push_back({CW'(ch), a});
    endtask

    task automatic write(input logic [AW-1:0] a);
        reach_thrh = 1'b1;
        i_fea_addr = a;
        tick();
        reach_thrh = 1'b0;
    endtask

    task automatic apply_reset();
        check("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        reach_thrh = 1'b0;
        i_fea_addr = '0;
        rd_req = '0;
        done = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_v", 32'(o_fea_addr_v), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow_cnt), 32'd0);
        check("rst_err", 32'(err_done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        #2;
        apply_reset();
        check("rst_addr", 32'(o_fea_addr), 32'd0);
        check("rst_ch", 32'(o_fea_ch), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);

        // basic dispatch
        expect_disp(12'h0A5, 0);
        write(12'h0A5);
        rd_req = 4'b0001;
        tick();
        check("basic_v", 32'(o_fea_addr_v), 32'd1);
        rd_req = 4'b0000;
        tick();
        check("basic_empty", 32'(fifo_empty), 32'd1);
        check("basic_v_off", 32'(o_fea_addr_v), 32'd0);
        check("basic_hold", 32'(o_fea_addr), 32'h0A5);

        // round robin, two laps, then credit exhaustion
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            expect_disp(12'h0A0 + AW'(i), i % NCH);
            write(12'h0A0 + AW'(i));
        end
        check("rr_level8", 32'(fifo_level), 32'd8);
        rd_req = 4'b1111;
        for (int i = 0; i < 12; i++) tick();
        check("rr_empty", 32'(fifo_empty), 32'd1);
        write(12'h0A8);
        for (int i = 0; i < 4; i++) tick();
        check("rr_stall_level", 32'(fifo_level), 32'd1);
        expect_disp(12'h0A8, 1);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        tick();
        tick();
        check("rr_ret_level", 32'(fifo_level), 32'd0);
        check("rr_err", 32'(err_done), 32'd0);
        rd_req = 4'b0000;
        tick();

        // credit stall and return latency on channel 2
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) expect_disp(12'h0B0 + AW'(i), 2);
            write(12'h0B0 + AW'(i));
        end
        rd_req = 4'b0100;
        for (int i = 0; i < 6; i++) tick();
        check("crd_stall_level", 32'(fifo_level), 32'd3);
        done = 4'b0100;
        tick();
        done = 4'b0000;
        check("crd_lat_t1", 32'(o_fea_addr_v), 32'd0);
        tick();
        check("crd_lat_t2", 32'(o_fea_addr_v), 32'd1);
        tick();
        tick();
        check("crd_level_after", 32'(fifo_level), 32'd2);
        rd_req = 4'b0000;
        tick();

        // overflow
        apply_reset();
        for (int i = 0; i < 17; i++) write(12'hC00 + AW'(i));
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_level", 32'(fifo_level), 32'd16);
        check("ovf_cnt1", 32'(overflow_cnt), 32'd1);
        expect_disp(12'hC00, 0);
        reach_thrh = 1'b1;
        i_fea_addr = 12'hFFF;
        rd_req = 4'b0001;
        tick();
        reach_thrh = 1'b0;
        rd_req = 4'b0000;
        check("ovf_pop_level", 32'(fifo_level), 32'd15);
        check("ovf_cnt2", 32'(overflow_cnt), 32'd2);
        check("ovf_notfull", 32'(fifo_full), 32'd0);
        tick();

        // grant and done on ch3 in the same cycle, then err_done
        apply_reset();
        expect_disp(12'h0D0, 3);
        expect_disp(12'h0D1, 3);
        write(12'h0D0);
        write(12'h0D1);
        rd_req = 4'b1000;
        tick();
        done = 4'b1000;
        tick();
        done = 4'b0000;
        rd_req = 4'b0000;
        tick();
        check("sim_err", 32'(err_done), 32'd0);
        expect_disp(12'h0D2, 3);
        write(12'h0D2);
        write(12'h0D3);
        rd_req = 4'b1000;
        for (int i = 0; i < 5; i++) tick();
        check("sim_infl_level", 32'(fifo_level), 32'd1);
        rd_req = 4'b0000;
        done = 4'b0010;
        tick();
        done = 4'b0000;
        check("err_set", 32'(err_done), 32'd1);
        tick();
        tick();
        check("err_sticky", 32'(err_done), 32'd1);

        // asynchronous reset mid-burst
        apply_reset();
        expect_disp(12'h0E0, 0);
        for (int i = 0; i < 5; i++) write(12'h0E0 + AW'(i));
        rd_req = 4'b0001;
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_v", 32'(o_fea_addr_v), 32'd0);
        check("arst_addr", 32'(o_fea_addr), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_empty", 32'(fifo_empty), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("arst_no_v", 32'(o_fea_addr_v), 32'd0);
        end
        expect_disp(12'h0F0, 0);
        write(12'h0F0);
        tick();
        check("arst_new_v", 32'(o_fea_addr_v), 32'd1);
        rd_req = 4'b0000;
        tick();
        tick();
        check("final_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
